apb_bridge_n: RTL and testbench
===============================

// Module: apb_bridge_n
// PURPOSE
//  Parametrised APB4 requester and N-way slave fabric, replacing the fixed two-slave master/decoder top.
//  Accepts one request at a time on a valid/ready port and runs the APB SETUP/ACCESS sequence.
//  Decodes the target slave from an address field, enforces a wait-state timeout, and returns one response pulse.
//  Sits between CPU-side logic and the GPIO/UART/etc. slaves.
// PARAMETERS
//  ADDR_W   32  address width (PADDR, req_addr)
//  DATA_W   32  data width, multiple of 8
//  NSLV     4   slave count, power of 2, >=2; IDX_W = clog2(NSLV)
//  SEL_LSB  12  slave index = addr[SEL_LSB +: IDX_W]; SEL_LSB+IDX_W <= ADDR_W
//  TIMEOUT  16  max ACCESS cycles waiting for PREADY; 0 = no timeout
// PORTS
//  PCLK       in   1              clock, rising edge
//  PRESETn    in   1              asynchronous, active-low reset
//  req_valid  in   1              request present
//  req_ready  out  1              request accepted when valid&ready
//  req_write  in   1              1 = write, 0 = read
//  req_addr   in   ADDR_W         byte address
//  req_wdata  in   DATA_W         write data
//  req_strb   in   DATA_W/8       write byte strobes
//  rsp_valid  out  1              one-cycle response pulse, no backpressure
//  rsp_rdata  out  DATA_W         read data; 0 on write or error
//  rsp_err    out  1              slave PSLVERR, decode miss or timeout
//  PSEL       out  NSLV           one-hot slave select
//  PENABLE    out  1              APB access phase
//  PWRITE     out  1              APB direction
//  PADDR      out  ADDR_W         APB address
//  PWDATA     out  DATA_W         APB write data
//  PSTRB      out  DATA_W/8       APB strobes; 0 on reads
//  PRDATA     in   NSLV*DATA_W    slave k data at [k*DATA_W +: DATA_W]
//  PREADY     in   NSLV           per-slave ready
//  PSLVERR    in   NSLV           per-slave error
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0 while PRESETn low; all other outputs 0.
//   A mid-transfer reset aborts without rsp_valid.
//  FSM: IDLE -> SETUP -> ACCESS -> IDLE. Decode miss: IDLE -> ERR -> IDLE.
//  IDLE: req_ready=1; PSEL=0, PENABLE=0; PADDR/PWRITE/PWDATA hold last values.
//   On valid&ready, register addr/write/wdata/strb and the decoded index.
//   Decode miss = any addr bit at or above SEL_LSB+IDX_W nonzero.
//   On a miss go to ERR; otherwise go to SETUP.
//  SETUP (1 cycle): PSEL[idx]=1, PENABLE=0. Outputs are driven from registers and stay stable until IDLE.
//  ACCESS: PSEL[idx]=1, PENABLE=1; wait_cnt increments each cycle PREADY[idx]=0.
//   PREADY[idx]=1: completion. Capture PRDATA slice (reads only) and PSLVERR[idx], then go to IDLE.
//   TIMEOUT!=0 and wait_cnt==TIMEOUT-1 with PREADY low: abort, drop PSEL/PENABLE, rsp_err=1, go to IDLE.
//   PREADY on the final allowed cycle wins over the timeout.
//  ERR (1 cycle): no PSEL asserted; completes with rsp_err=1.
//  Response: rsp_valid registered, high exactly in the first IDLE cycle after completion.
//   rsp_rdata/rsp_err are valid with it and hold until the next rsp_valid.
//  Back-to-back: a request may be accepted in the same cycle rsp_valid is high.
//   Zero-wait throughput is 1 transfer per 3 cycles; latency from accept to rsp_valid is 3+W cycles for W wait states.
//  Unselected slaves' PREADY/PSLVERR/PRDATA are ignored; PSEL is never multi-hot.
//  PSTRB = req_strb on writes, 0 on reads. rsp_rdata = 0 on writes, errors and timeouts.
//  wait_cnt width = clog2(TIMEOUT+1); it clears on entry to SETUP.
// STRUCTURE
//  apb_defs.vh: state encodings (IDLE/SETUP/ACCESS/ERR), clog2 function, shared with slaves and the bench.
//  Sub-module apb_addr_decode (combinational): addr -> idx, one-hot sel, miss flag.
//  FSM, request registers, timeout counter and response registers live in apb_bridge_n.
// TESTING
//  1 Write 0x0000_1004 data 0xA5A5_5A5A strb 0xF, slave1 zero-wait -> PSEL=0010 SETUP then ACCESS;
//    rsp_valid 3 cycles after accept, rsp_err=0.
//  2 Read 0x0000_3000, slave3 PRDATA=0xDEAD_BEEF, PREADY low 2 cycles -> PSTRB=0, PADDR stable 4 cycles;
//    rsp_rdata=0xDEAD_BEEF at cycle 5.
//  3 Read 0x0001_0000 (bit above index) -> no PSEL ever asserted; rsp_valid with rsp_err=1, rsp_rdata=0 after 2 cycles.
//  4 TIMEOUT=16, slave2 never ready -> ACCESS lasts 16 cycles, PSEL drops, rsp_err=1;
//    repeat with PREADY on the 16th cycle -> rsp_err=0.
//  5 Slave0 returns PSLVERR=1 with PREADY -> rsp_err=1; then issue back-to-back writes in the rsp_valid cycle
//    -> accepted, second SETUP follows immediately.
//  6 Drop PRESETn during ACCESS -> PSEL/PENABLE=0 asynchronously, no rsp_valid; after release the next request completes normally.

Source files
------------

// File: rtl/apb_bridge_n_pkg.sv
// Shared types and helpers for the N-way APB bridge: FSM state encoding and width helpers.
package apb_bridge_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  // Ceiling log2 that returns 0 for 0 and 1, so it can size index fields directly.
  function automatic int clog2(input int v);
    return (v <= 1) ? 0 : $clog2(v);
  endfunction

endpackage

// File: rtl/apb_bridge_n_if.sv
// Request/response port and APB fabric signals of the bridge, bundled with bridge-side and far-side modports.
interface apb_bridge_n_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV   = 4
);
  // Request transfers on the rising edge where req_valid & req_ready are both high; the requester
  // keeps req_* stable while req_valid waits. rsp_valid is a single-cycle pulse with no backpressure.
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_W-1:0]      req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic [DATA_W/8-1:0]    req_strb;
  logic                   rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  logic [NSLV-1:0]        PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic [DATA_W/8-1:0]    PSTRB;
  logic [NSLV*DATA_W-1:0] PRDATA;
  logic [NSLV-1:0]        PREADY;
  logic [NSLV-1:0]        PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

endinterface

// File: rtl/apb_bridge_n_addr_decode.sv
// Combinational slave decoder: index field, one-hot select and out-of-range miss flag from a byte address.
module apb_bridge_n_addr_decode
  import apb_bridge_n_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int NSLV    = 4,
  parameter  int SEL_LSB = 12,
  localparam int IDX_W   = clog2(NSLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic [NSLV-1:0]   sel,
  output logic              miss
);

  localparam logic [NSLV-1:0] SEL_ONE = NSLV'(1);

  assign idx  = addr[SEL_LSB +: IDX_W];
  assign sel  = SEL_ONE << idx;
  // Anything set above the index field falls outside the slave window.
  assign miss = |(addr >> (SEL_LSB + IDX_W));

endmodule

// File: rtl/apb_bridge_n.sv
// APB4 requester with N-way slave decode: one request at a time, SETUP/ACCESS sequencing,
// wait-state timeout and a single registered response pulse.
module apb_bridge_n
  import apb_bridge_n_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_bridge_n_if.master bus,
  output state_t         state_dbg
);

  localparam int IDX_W   = clog2(NSLV);
  localparam int STRB_W  = DATA_W / 8;
  localparam int WCNT_W  = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t            state;
  logic [IDX_W-1:0]  idx_q;
  logic [WCNT_W-1:0] wait_cnt;

  logic [IDX_W-1:0]  dec_idx;
  logic [NSLV-1:0]   dec_sel;
  logic              dec_miss;

  apb_bridge_n_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NSLV    (NSLV),
    .SEL_LSB (SEL_LSB)
  ) u_decode (
    .addr (bus.req_addr),
    .idx  (dec_idx),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  assign state_dbg = state;

  // req_ready is registered, so it rises on the first clock edge after reset release.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= ST_IDLE;
      idx_q         <= '0;
      wait_cnt      <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.PSEL      <= '0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.PSTRB     <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.PADDR     <= bus.req_addr;
            bus.PWRITE    <= bus.req_write;
            bus.PWDATA    <= bus.req_wdata;
            bus.PSTRB     <= bus.req_write ? bus.req_strb : STRB_W'(0);
            idx_q         <= dec_idx;
            bus.req_ready <= 1'b0;
            if (dec_miss) begin
              state <= ST_ERR;
            end else begin
              state    <= ST_SETUP;
              bus.PSEL <= dec_sel;
              wait_cnt <= '0;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // A ready slave on the last allowed cycle takes priority over the timeout.
          if (bus.PREADY[idx_q]) begin
            state         <= ST_IDLE;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.PSLVERR[idx_q];
            bus.rsp_rdata <= (!bus.PWRITE && !bus.PSLVERR[idx_q])
                             ? bus.PRDATA[idx_q*DATA_W +: DATA_W] : DATA_W'(0);
          end else if ((TIMEOUT != 0) && (wait_cnt == WCNT_W'(TO_LAST))) begin
            state         <= ST_IDLE;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_ERR: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b1;
          bus.rsp_rdata <= '0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_n.sv
// Directed bench for apb_bridge_n: reset, zero-wait write, waited read, decode miss, timeout,
// slave error with back-to-back traffic, and reset during an access.
module tb_apb_bridge_n;
  import apb_bridge_n_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t state_dbg;
  int     checks;
  int     failures;
  logic [32:0] exp_q[$];

  apb_bridge_n_if #(.ADDR_W(32), .DATA_W(32), .NSLV(4)) bus ();

  apb_bridge_n #(
    .ADDR_W (32), .DATA_W (32), .NSLV (4), .SEL_LSB (12), .TIMEOUT (16)
  ) dut (
    .PCLK      (clk),
    .PRESETn   (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_strb  = s;
    bus.req_valid = 1'b1;
  endtask

  task automatic set_slave_data(input int k, input logic [31:0] d);
    bus.PRDATA[k*32 +: 32] = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0) begin failures++; $display("FAIL rst_psel got=%b/%b exp=0000/0", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp got=%b/%b/%h exp=0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    checks++; if (bus.PADDR !== 32'h0 || bus.PSTRB !== 4'h0 || bus.PWRITE !== 1'b0) begin failures++; $display("FAIL rst_bus got=%h/%h/%b exp=0", bus.PADDR, bus.PSTRB, bus.PWRITE); end
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rel got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_write_zero_wait;
    bus.PREADY  = 4'b0010;
    bus.PSLVERR = 4'b0000;
    @(negedge clk);
    drive_req(1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b0) begin failures++; $display("FAIL wr_setup got=%b/%b exp=0010/0", bus.PSEL, bus.PENABLE); end
    checks++; if (bus.PADDR !== 32'h0000_1004 || bus.PWRITE !== 1'b1 || bus.PWDATA !== 32'hA5A5_5A5A || bus.PSTRB !== 4'hF) begin failures++; $display("FAIL wr_bus got=%h/%b/%h/%h exp=00001004/1/a5a55a5a/f", bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB); end
    @(negedge clk);
    checks++; if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_access got=%b/%b/%b exp=0010/1/0", bus.PSEL, bus.PENABLE, bus.rsp_valid); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    checks++; if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0 || state_dbg !== ST_IDLE) begin failures++; $display("FAIL wr_idle got=%b/%b/%0d exp=0000/0/0", bus.PSEL, bus.PENABLE, state_dbg); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_pulse got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_read_wait;
    int stable;
    int early;
    stable = 0;
    early  = 0;
    bus.PREADY  = 4'b0111;
    bus.PSLVERR = 4'b0100;
    set_slave_data(3, 32'hDEAD_BEEF);
    set_slave_data(2, 32'h1234_5678);
    @(negedge clk);
    drive_req(1'b0, 32'h0000_3000, 32'hFFFF_FFFF, 4'hF);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (c < 5 && bus.PSEL == 4'b1000 && bus.PADDR == 32'h0000_3000 && bus.PSTRB == 4'h0 && bus.PWRITE == 1'b0) stable++;
      if (c < 5 && bus.rsp_valid) early++;
      if (c == 4) bus.PREADY = 4'b1111;
    end
    checks++; if (stable !== 4) begin failures++; $display("FAIL rd_stable got=%0d exp=4", stable); end
    checks++; if (early !== 0) begin failures++; $display("FAIL rd_early got=%0d exp=0", early); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp got=%b/%h/%b exp=1/deadbeef/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
  endtask

  task automatic test_decode_miss;
    logic [3:0] psel_seen;
    psel_seen   = 4'b0000;
    bus.PREADY  = 4'b1111;
    bus.PSLVERR = 4'b0000;
    @(negedge clk);
    drive_req(1'b0, 32'h0001_0000, 32'h0, 4'hF);
    @(negedge clk);
    bus.req_valid = 1'b0;
    psel_seen = psel_seen | bus.PSEL;
    checks++; if (state_dbg !== ST_ERR || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL miss_err_state got=%0d/%b exp=%0d/0", state_dbg, bus.rsp_valid, ST_ERR); end
    @(negedge clk);
    psel_seen = psel_seen | bus.PSEL;
    checks++; if (psel_seen !== 4'b0000) begin failures++; $display("FAIL miss_psel got=%b exp=0000", psel_seen); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL miss_rsp got=%b/%b/%h exp=1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
  endtask

  task automatic test_timeout;
    for (int run = 0; run < 2; run++) begin
      int acc;
      int rsp_c;
      acc   = 0;
      rsp_c = -1;
      bus.PREADY  = 4'b1011;
      bus.PSLVERR = 4'b0000;
      set_slave_data(2, 32'hCAFE_F00D);
      @(negedge clk);
      if (run == 0) drive_req(1'b1, 32'h0000_2000, 32'h5555_AAAA, 4'h3);
      else          drive_req(1'b0, 32'h0000_2008, 32'h0, 4'h0);
      for (int c = 1; c <= 40 && rsp_c < 0; c++) begin
        @(negedge clk);
        if (c == 1) bus.req_valid = 1'b0;
        if (bus.PSEL == 4'b0100 && bus.PENABLE) acc++;
        if (bus.rsp_valid) rsp_c = c;
        if (run == 1 && c == 17) bus.PREADY = 4'b1111;
      end
      checks++; if (rsp_c !== 18) begin failures++; $display("FAIL to%0d_latency got=%0d exp=18", run, rsp_c); end
      checks++; if (acc !== 16) begin failures++; $display("FAIL to%0d_access got=%0d exp=16", run, acc); end
      checks++; if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0) begin failures++; $display("FAIL to%0d_drop got=%b/%b exp=0000/0", run, bus.PSEL, bus.PENABLE); end
      if (run == 0) begin
        checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL to0_rsp got=%b/%h exp=1/0", bus.rsp_err, bus.rsp_rdata); end
      end else begin
        checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL to1_rsp got=%b/%h exp=0/cafef00d", bus.rsp_err, bus.rsp_rdata); end
      end
    end
  endtask

  task automatic test_slverr_back_to_back;
    int rsp_cyc[3];
    int nrsp;
    int multi;
    logic [32:0] got;
    logic [32:0] exp;
    nrsp  = 0;
    multi = 0;
    foreach (rsp_cyc[i]) rsp_cyc[i] = -1;
    bus.PREADY  = 4'b1111;
    bus.PSLVERR = 4'b0001;
    set_slave_data(0, 32'h0BAD_0BAD);
    set_slave_data(2, 32'h600D_F00D);
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h600D_F00D});
    @(negedge clk);
    drive_req(1'b1, 32'h0000_0010, 32'h0102_0304, 4'hF);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if ($countones(bus.PSEL) > 1) multi++;
      if (c == 4) begin
        checks++; if (bus.PSEL !== 4'b0010 || bus.PENABLE !== 1'b0) begin failures++; $display("FAIL b2b_setup got=%b/%b exp=0010/0", bus.PSEL, bus.PENABLE); end
      end
      if (bus.rsp_valid) begin
        got = {bus.rsp_err, bus.rsp_rdata};
        if (exp_q.size() == 0) exp = 33'h1_FFFF_FFFF;
        else exp = exp_q.pop_front();
        checks++; if (got !== exp) begin failures++; $display("FAIL b2b_rsp%0d got=%h exp=%h", nrsp, got, exp); end
        if (nrsp < 3) rsp_cyc[nrsp] = c;
        nrsp++;
        if (nrsp < 3) begin
          checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", nrsp, bus.req_ready); end
          if (nrsp == 1) drive_req(1'b1, 32'h0000_1008, 32'h1111_2222, 4'h5);
          else           drive_req(1'b0, 32'h0000_2004, 32'h0, 4'hF);
        end
      end
    end
    checks++; if (rsp_cyc[0] !== 3 || rsp_cyc[1] !== 6 || rsp_cyc[2] !== 9) begin failures++; $display("FAIL b2b_timing got=%0d,%0d,%0d exp=3,6,9", rsp_cyc[0], rsp_cyc[1], rsp_cyc[2]); end
    checks++; if (exp_q.size() !== 0 || nrsp !== 3) begin failures++; $display("FAIL b2b_count got=%0d left=%0d exp=3 left=0", nrsp, exp_q.size()); end
    checks++; if (multi !== 0) begin failures++; $display("FAIL b2b_onehot got=%0d exp=0", multi); end
  endtask

  task automatic test_reset_abort;
    int seen;
    int rsp_c;
    seen  = 0;
    rsp_c = -1;
    bus.PREADY  = 4'b0000;
    bus.PSLVERR = 4'b0000;
    @(negedge clk);
    drive_req(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.PENABLE !== 1'b1 || bus.PSEL !== 4'b1000) begin failures++; $display("FAIL ra_pre got=%b/%b exp=1000/1", bus.PSEL, bus.PENABLE); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0 || bus.req_ready !== 1'b0) begin failures++; $display("FAIL ra_async got=%b/%b/%b exp=0000/0/0", bus.PSEL, bus.PENABLE, bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.PREADY = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL ra_no_rsp got=%0d exp=0", seen); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ra_ready got=%b exp=1", bus.req_ready); end
    drive_req(1'b1, 32'h0000_1000, 32'h0BAD_CAFE, 4'h3);
    for (int c = 1; c <= 10 && rsp_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b0;
        checks++; if (bus.PSEL !== 4'b0010 || bus.PSTRB !== 4'h3 || bus.PWDATA !== 32'h0BAD_CAFE) begin failures++; $display("FAIL ra_setup got=%b/%h/%h exp=0010/3/0badcafe", bus.PSEL, bus.PSTRB, bus.PWDATA); end
      end
      if (bus.rsp_valid) rsp_c = c;
    end
    checks++; if (rsp_c !== 3 || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL ra_after got=%0d/%b exp=3/0", rsp_c, bus.rsp_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;
    test_reset;
    test_write_zero_wait;
    test_read_wait;
    test_decode_miss;
    test_timeout;
    test_slverr_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
